// File: rtl/caxi4interconnect_thread_tracker_pkg.sv
// Shared parameters for the interconnect thread tracker: default slot field
// widths, the saturation limit and the per-slot update operations.
package caxi4interconnect_thread_tracker_pkg;

  localparam int TT_NUM_SLAVES_WIDTH  = 2;
  localparam int TT_MASTERID_WIDTH    = 4;
  localparam int TT_NUM_THREADS       = 2;
  localparam int TT_NUM_THREADS_WIDTH = 1;
  localparam int TT_OPEN_TRANS_MAX    = 3;
  localparam int TT_OPEN_TRANS_WIDTH  = 2;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_INC   = 2'd1,
    SLOT_DEC   = 2'd2,
    SLOT_ALLOC = 2'd3
  } slot_op_e;

endpackage

// File: rtl/caxi4interconnect_thread_slot.sv
// One thread slot: occupied flag, transaction ID, target slave and
// outstanding count, updated by alloc/inc/dec strobes from the tracker.
module caxi4interconnect_thread_slot
  import caxi4interconnect_thread_tracker_pkg::*;
#(
  parameter int NUM_SLAVES_WIDTH = TT_NUM_SLAVES_WIDTH,
  parameter int MASTERID_WIDTH   = TT_MASTERID_WIDTH,
  parameter int OPEN_TRANS_WIDTH = TT_OPEN_TRANS_WIDTH
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic                        alloc_i,
  input  logic                        inc_i,
  input  logic                        dec_i,
  input  logic [MASTERID_WIDTH-1:0]   id_i,
  input  logic [NUM_SLAVES_WIDTH-1:0] slave_i,
  output logic                        occupied_o,
  output logic [MASTERID_WIDTH-1:0]   id_o,
  output logic [NUM_SLAVES_WIDTH-1:0] slave_o,
  output logic [OPEN_TRANS_WIDTH-1:0] count_o
);

  logic                        occ_q, occ_d;
  logic [MASTERID_WIDTH-1:0]   id_q, id_d;
  logic [NUM_SLAVES_WIDTH-1:0] slave_q, slave_d;
  logic [OPEN_TRANS_WIDTH-1:0] count_q, count_d;
  slot_op_e                    op;

  // Inc and dec together cancel out, keeping the slot occupied.
  always_comb begin
    op = SLOT_HOLD;
    if (alloc_i)              op = SLOT_ALLOC;
    else if (inc_i && !dec_i) op = SLOT_INC;
    else if (dec_i && !inc_i) op = SLOT_DEC;
  end

  always_comb begin
    occ_d   = occ_q;
    id_d    = id_q;
    slave_d = slave_q;
    count_d = count_q;
    case (op)
      SLOT_ALLOC: begin
        occ_d   = 1'b1;
        id_d    = id_i;
        slave_d = slave_i;
        count_d = OPEN_TRANS_WIDTH'(1);
      end
      SLOT_INC: count_d = count_q + OPEN_TRANS_WIDTH'(1);
      SLOT_DEC: begin
        if (count_q == OPEN_TRANS_WIDTH'(1)) begin
          occ_d   = 1'b0;
          count_d = '0;
        end else begin
          count_d = count_q - OPEN_TRANS_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      occ_q   <= 1'b0;
      id_q    <= '0;
      slave_q <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      id_q    <= id_d;
      slave_q <= slave_d;
      count_q <= count_d;
    end
  end

  assign occupied_o = occ_q;
  assign id_o       = id_q;
  assign slave_o    = slave_q;
  assign count_o    = count_q;

endmodule

// File: rtl/caxi4interconnect_thread_tracker.sv
// Tracks outstanding AXI transaction threads by ID: combinational lookup of
// the current request ID, slot allocation, counting and error pulses.
module caxi4interconnect_thread_tracker
  import caxi4interconnect_thread_tracker_pkg::*;
#(
  parameter int NUM_SLAVES_WIDTH  = TT_NUM_SLAVES_WIDTH,
  parameter int MASTERID_WIDTH    = TT_MASTERID_WIDTH,
  parameter int NUM_THREADS       = TT_NUM_THREADS,
  parameter int NUM_THREADS_WIDTH = TT_NUM_THREADS_WIDTH,
  parameter int OPEN_TRANS_MAX    = TT_OPEN_TRANS_MAX,
  parameter int OPEN_TRANS_WIDTH  = TT_OPEN_TRANS_WIDTH
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [MASTERID_WIDTH-1:0]   currTransID,
  input  logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID,
  input  logic                        openTransInc,
  input  logic                        openTransDec,
  input  logic [MASTERID_WIDTH-1:0]   respID,
  output logic                        threadAvail,
  output logic                        threadValid,
  output logic [OPEN_TRANS_WIDTH-1:0] threadCount,
  output logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
  output logic                        incErr,
  output logic                        decErr
);

  logic [NUM_THREADS-1:0]       occ, match_curr, match_resp;
  logic [NUM_THREADS-1:0]       slot_alloc, slot_inc, slot_dec;
  logic [MASTERID_WIDTH-1:0]    slot_id    [NUM_THREADS];
  logic [NUM_SLAVES_WIDTH-1:0]  slot_slave [NUM_THREADS];
  logic [OPEN_TRANS_WIDTH-1:0]  slot_count [NUM_THREADS];
  logic [NUM_THREADS_WIDTH-1:0] hit_idx, free_idx;
  logic [OPEN_TRANS_WIDTH-1:0]  hit_count;
  logic                         hit, resp_hit, avail, at_max, inc_ok, do_alloc;
  logic                         inc_err_q, inc_err_d, dec_err_q, dec_err_d;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_slot
    caxi4interconnect_thread_slot #(
      .NUM_SLAVES_WIDTH(NUM_SLAVES_WIDTH),
      .MASTERID_WIDTH  (MASTERID_WIDTH),
      .OPEN_TRANS_WIDTH(OPEN_TRANS_WIDTH)
    ) u_slot (
      .sysClk    (sysClk),
      .sysReset  (sysReset),
      .alloc_i   (slot_alloc[g]),
      .inc_i     (slot_inc[g]),
      .dec_i     (slot_dec[g]),
      .id_i      (currTransID),
      .slave_i   (currTransSlaveID),
      .occupied_o(occ[g]),
      .id_o      (slot_id[g]),
      .slave_o   (slot_slave[g]),
      .count_o   (slot_count[g])
    );

    assign match_curr[g] = occ[g] && (slot_id[g] == currTransID);
    assign match_resp[g] = occ[g] && (slot_id[g] == respID);
    assign slot_inc[g]   = inc_ok && match_curr[g];
    assign slot_alloc[g] = do_alloc && (free_idx == NUM_THREADS_WIDTH'(g));
    assign slot_dec[g]   = openTransDec && match_resp[g];
  end

  // IDs are unique across slots, so the match vector is at most one-hot.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (match_curr[i]) hit_idx = hit_idx | NUM_THREADS_WIDTH'(i);
    end
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (!occ[i]) free_idx = NUM_THREADS_WIDTH'(i);
    end
  end

  assign hit       = |match_curr;
  assign resp_hit  = |match_resp;
  assign avail     = |(~occ);
  assign hit_count = slot_count[hit_idx];
  assign at_max    = (hit_count == OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX));
  assign inc_ok    = openTransInc && hit && !at_max;
  // Free flags come from registered state, so a slot freed this cycle is not reused yet.
  assign do_alloc  = openTransInc && !hit && avail;
  assign inc_err_d = openTransInc && (hit ? at_max : !avail);
  assign dec_err_d = openTransDec && !resp_hit;

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      inc_err_q <= 1'b0;
      dec_err_q <= 1'b0;
    end else begin
      inc_err_q <= inc_err_d;
      dec_err_q <= dec_err_d;
    end
  end

  assign threadAvail   = avail;
  assign threadValid   = hit;
  assign threadCount   = hit ? hit_count : '0;
  assign threadSlaveID = hit ? slot_slave[hit_idx] : '0;
  assign incErr        = inc_err_q;
  assign decErr        = dec_err_q;

endmodule

// File: doc/caxi4interconnect_thread_tracker.md
CAXI4INTERCONNECT_THREAD_TRACKER -- requirements
Module: caxi4interconnect_thread_tracker

Interface
REQ-001 Parameters SHALL be as follows; per-thread packed vectors are permitted but not required.
- NUM_SLAVES_WIDTH, default 2, slave ID width.
- MASTERID_WIDTH, default 4, transaction ID width.
- NUM_THREADS, default 2, number of thread slots.
- NUM_THREADS_WIDTH, default 1, slot index width.
- OPEN_TRANS_MAX, default 3, maximum outstanding transactions per thread.
- OPEN_TRANS_WIDTH, default 2, outstanding-count width.
REQ-002 There SHALL be one clock and the reset SHALL be asynchronous, active-low:
- sysClk  in  1  clock.
- sysReset  in  1  reset.
REQ-003 Lookup inputs:
- currTransID  in  MASTERID_WIDTH  ID of the current address request; the lookup key.
- currTransSlaveID  in  NUM_SLAVES_WIDTH  decoded target slave of the current request.
REQ-004 Update inputs:
- openTransInc  in  1  address handshake accepted for currTransID.
- openTransDec  in  1  final response completed.
- respID  in  MASTERID_WIDTH  ID of the completed response.
REQ-005 Lookup outputs:
- threadAvail  out  1  at least one free slot.
- threadValid  out  1  currTransID matches an occupied slot.
- threadCount  out  OPEN_TRANS_WIDTH  outstanding count of the matched slot.
- threadSlaveID  out  NUM_SLAVES_WIDTH  slave of the matched slot.
REQ-006 Error outputs:
- incErr  out  1  one-cycle pulse on an illegal increment.
- decErr  out  1  one-cycle pulse on an unmatched decrement.

Function
REQ-007 Each slot SHALL hold: occupied flag, ID, slaveID, count.
REQ-008 An occupied slot SHALL always have count >= 1.
REQ-009 Lookup SHALL be combinational, with zero latency from currTransID.
- Match: the occupied slot whose ID equals currTransID.
- No match: threadValid=0, threadCount=0, threadSlaveID=0.
REQ-010 threadAvail SHALL be the OR of all inverted occupied flags of registered state.
REQ-011 openTransInc with a matching slot whose count < OPEN_TRANS_MAX SHALL increment that count at the next edge.
REQ-012 openTransInc with no match and a free slot SHALL allocate the lowest-index free slot with ID=currTransID, slaveID=currTransSlaveID, count=1.
REQ-013 openTransInc with count==OPEN_TRANS_MAX, or with no match and no free slot, SHALL leave state unchanged and pulse incErr the next cycle.
REQ-014 openTransDec SHALL decrement the slot whose ID equals respID; at count 1 the slot SHALL be freed and count cleared.
REQ-015 openTransDec with no matching slot SHALL leave state unchanged and pulse decErr the next cycle.
REQ-016 Simultaneous Inc and Dec on the same slot SHALL leave the count unchanged, and the slot SHALL stay occupied.
REQ-017 Simultaneous Inc and Dec on different slots SHALL apply both updates independently.
REQ-018 A slot freed by Dec SHALL NOT be allocatable by an Inc in the same cycle; it becomes available the next cycle.
REQ-019 slaveID SHALL be written only on allocation; increments SHALL NOT alter it.
REQ-020 All updates SHALL take effect at the rising sysClk edge and be visible on the lookup outputs the following cycle.

Reset
REQ-021 While sysReset=0, all occupied flags, IDs, slaveIDs and counts SHALL be 0.
REQ-022 While sysReset=0, the outputs SHALL be threadAvail=1, threadValid=0, threadCount=0, threadSlaveID=0, incErr=0, decErr=0.
REQ-023 Reset asserted mid-operation SHALL discard all outstanding threads immediately, without waiting for a clock edge.

Structure
REQ-024 Slot field widths and the OPEN_TRANS_MAX compare constant SHALL reside in the shared interconnect parameter package or include.
REQ-025 Per-slot storage and update logic SHALL be one sub-module, caxi4interconnect_thread_slot, instantiated NUM_THREADS times.
REQ-026 Free-slot priority select and match one-hot to index encoding SHALL reside at top level.

Verification
REQ-027 All scenarios below use NUM_THREADS=2, OPEN_TRANS_MAX=3; the bench SHALL cover each.
- Alloc: Inc ID=5, slave=1 -> next cycle lookup ID 5 gives threadValid=1, threadCount=1, threadSlaveID=1, threadAvail=1.
- Saturate: three Inc on ID=5, then a fourth -> count stays 3 and incErr pulses once.
- Full: allocate IDs 5 and 6; Inc ID=7 -> threadAvail=0, incErr=1, no state change.
- Simultaneous: count(5)=2; Inc ID=5 and Dec respID=5 in the same cycle -> count stays 2.
- Free and reuse: count(6)=1, Dec respID=6 with Inc ID=7 in the same cycle -> incErr=1; Inc ID=7 the next cycle -> allocated in slot 1.
- Reset: reset asserted with two occupied slots -> threadAvail=1 and threadValid=0 immediately, before the next clock edge.
